// File: rtl/axi_mem_responder.sv
// AXI memory-side responder: word-addressed storage behind independent
// read and write channels, one outstanding transaction per channel.
module axi_mem_responder #(
    parameter int ADDR_WIDTH     = 26,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int READ_LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [3:0]            AWID,
    input  logic [3:0]            AWLEN,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic                  WLAST,
    input  logic [3:0]            WID,
    input  logic [DATA_WIDTH-1:0] WDATA,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [3:0]            BID,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [3:0]            ARID,
    input  logic [3:0]            ARLEN,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  RLAST,
    output logic [3:0]            RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  protocol_error
);
    localparam int IW = MEM_WORDS_LOG2;
    localparam logic [IW-1:0] IDX_ONE = 1;
    localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_WIDTH-1:0] mem [0:(1<<IW)-1];

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;

    logic [IW-1:0] r_idx, w_idx;
    logic [3:0]    r_len, r_beat, r_cnt;
    logic [3:0]    w_len, w_beat, w_id;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    assign ar_hs = ARVALID & ARREADY;
    assign r_hs  = RVALID  & RREADY;
    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID  & WREADY;
    assign b_hs  = BVALID  & BREADY;

    // state registers for both channel FSMs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    // read channel next-state
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_WAIT;
            R_WAIT:  if (r_cnt == 4'd0) r_next = R_BURST;
            R_BURST: if (r_hs && RLAST) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // write channel next-state
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (aw_hs) w_next = W_DATA;
            W_DATA: if (w_hs && (w_beat == w_len)) w_next = W_RESP;
            W_RESP: if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // read datapath: latency countdown, beat load, and registered R outputs.
    // mem is sampled here before the write block's NBA lands, so a same-edge
    // collision returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ARREADY <= 1'b1;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RID     <= 4'd0;
            RDATA   <= '0;
            r_idx   <= '0;
            r_len   <= 4'd0;
            r_beat  <= 4'd0;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    RID     <= ARID;
                    r_idx   <= ARADDR[IW-1:0];
                    r_len   <= ARLEN;
                    r_cnt   <= LAT_INIT;
                    ARREADY <= 1'b0;
                end
                R_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        RDATA  <= mem[r_idx];
                        RVALID <= 1'b1;
                        RLAST  <= (r_len == 4'd0);
                        r_beat <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_BURST: if (r_hs) begin
                    if (RLAST) begin
                        RVALID  <= 1'b0;
                        RLAST   <= 1'b0;
                        ARREADY <= 1'b1;
                    end else begin
                        r_idx  <= r_idx + IDX_ONE;
                        r_beat <= r_beat + 4'd1;
                        RDATA  <= mem[r_idx + IDX_ONE];
                        RLAST  <= ((r_beat + 4'd1) == r_len);
                    end
                end
                default: ;
            endcase
        end
    end

    // write datapath: beat tracking, sticky protocol check, B response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AWREADY        <= 1'b1;
            WREADY         <= 1'b0;
            BVALID         <= 1'b0;
            BID            <= 4'd0;
            protocol_error <= 1'b0;
            w_idx          <= '0;
            w_len          <= 4'd0;
            w_beat         <= 4'd0;
            w_id           <= 4'd0;
        end else begin
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    w_id    <= AWID;
                    w_idx   <= AWADDR[IW-1:0];
                    w_len   <= AWLEN;
                    w_beat  <= 4'd0;
                    AWREADY <= 1'b0;
                    WREADY  <= 1'b1;
                end
                W_DATA: if (w_hs) begin
                    w_idx  <= w_idx + IDX_ONE;
                    w_beat <= w_beat + 4'd1;
                    if ((WLAST != (w_beat == w_len)) || (WID != w_id))
                        protocol_error <= 1'b1;
                    if (w_beat == w_len) begin
                        WREADY <= 1'b0;
                        BVALID <= 1'b1;
                        BID    <= w_id;
                    end
                end
                W_RESP: if (b_hs) begin
                    BVALID  <= 1'b0;
                    AWREADY <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // storage write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_state == W_DATA && w_hs)
            mem[w_idx] <= WDATA;
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: single/burst transfers, read
// backpressure, index wrap, protocol error, concurrency and async reset.
module tb_axi_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        AWVALID = 0, AWREADY;
    logic [3:0]  AWID = 0, AWLEN = 0;
    logic [25:0] AWADDR = 0;
    logic        WVALID = 0, WREADY, WLAST = 0;
    logic [3:0]  WID = 0;
    logic [31:0] WDATA = 0;
    logic        BVALID, BREADY = 0;
    logic [3:0]  BID;
    logic        ARVALID = 0, ARREADY;
    logic [3:0]  ARID = 0, ARLEN = 0;
    logic [25:0] ARADDR = 0;
    logic        RVALID, RREADY = 0, RLAST;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic        protocol_error;

    int n_chk = 0;
    int n_pass = 0;

    axi_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic sig(input int s);
        case (s)
            0: return AWREADY;
            1: return WREADY;
            2: return BVALID;
            3: return ARREADY;
            4: return RVALID;
            default: return 1'b0;
        endcase
    endfunction

    // wait (bounded) until the selected DUT signal is high, sampled 1ns after an edge
    task automatic wait_hi(input int s, input string tag);
        int n = 0;
        while (sig(s) !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [25:0] addr, input logic [3:0] len,
                            input logic [31:0] d0, input bit bad_last, input logic [3:0] wid);
        AWVALID = 1; AWID = id; AWADDR = addr; AWLEN = len;
        wait_hi(0, "awready");
        @(posedge clk); #1;
        AWVALID = 0;
        for (int i = 0; i <= int'(len); i++) begin
            WVALID = 1; WDATA = d0 + i; WID = wid;
            WLAST = (i == int'(len)) ^ bad_last;
            wait_hi(1, "wready");
            @(posedge clk); #1;
        end
        WVALID = 0; WLAST = 0;
        BREADY = 1;
        wait_hi(2, "bvalid");
        chk("bid", {28'd0, BID}, {28'd0, id});
        @(posedge clk); #1;
        BREADY = 0;
        chk("bvalid_clr", {31'd0, BVALID}, 32'd0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [25:0] addr, input logic [3:0] len,
                           input logic [31:0] d0, input int stall_beat, input int stall_n);
        RREADY = 1;
        ARVALID = 1; ARID = id; ARADDR = addr; ARLEN = len;
        wait_hi(3, "arready");
        @(posedge clk); #1;
        ARVALID = 0;
        chk("rvalid_lat0", {31'd0, RVALID}, 32'd0);
        chk("arready_busy", {31'd0, ARREADY}, 32'd0);
        @(posedge clk); #1;
        chk("rvalid_lat1", {31'd0, RVALID}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i <= int'(len); i++) begin
            chk("rvalid", {31'd0, RVALID}, 32'd1);
            chk("rdata", RDATA, d0 + i);
            chk("rlast", {31'd0, RLAST}, {31'd0, i == int'(len)});
            chk("rid", {28'd0, RID}, {28'd0, id});
            chk("arready_low", {31'd0, ARREADY}, 32'd0);
            if (i == stall_beat) begin
                RREADY = 0;
                repeat (stall_n) begin
                    @(posedge clk); #1;
                    chk("hold_valid", {31'd0, RVALID}, 32'd1);
                    chk("hold_data", RDATA, d0 + i);
                    chk("hold_last", {31'd0, RLAST}, {31'd0, i == int'(len)});
                end
                RREADY = 1;
            end
            @(posedge clk); #1;
        end
        chk("rvalid_end", {31'd0, RVALID}, 32'd0);
        chk("arready_back", {31'd0, ARREADY}, 32'd1);
        RREADY = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_arready", {31'd0, ARREADY}, 32'd1);
        chk("rst_awready", {31'd0, AWREADY}, 32'd1);
        chk("rst_rvalid", {31'd0, RVALID}, 32'd0);
        chk("rst_rlast", {31'd0, RLAST}, 32'd0);
        chk("rst_rid", {28'd0, RID}, 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_wready", {31'd0, WREADY}, 32'd0);
        chk("rst_bvalid", {31'd0, BVALID}, 32'd0);
        chk("rst_bid", {28'd0, BID}, 32'd0);
        chk("rst_perr", {31'd0, protocol_error}, 32'd0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // single write then read
        do_write(4'd3, 26'h10, 4'd0, 32'hDEADBEEF, 1'b0, 4'd3);
        do_read(4'd5, 26'h10, 4'd0, 32'hDEADBEEF, -1, 0);

        // 4-beat burst, then same burst with 3-cycle stall at beat 1
        do_write(4'd1, 26'h20, 4'd3, 32'h100, 1'b0, 4'd1);
        do_read(4'd2, 26'h20, 4'd3, 32'h100, -1, 0);
        do_read(4'd6, 26'h20, 4'd3, 32'h100, 1, 3);

        // index wrap at the top of storage
        do_write(4'd7, 26'hFFF, 4'd1, 32'hA0, 1'b0, 4'd7);
        do_read(4'd8, 26'h1000, 4'd0, 32'hA1, -1, 0);
        do_read(4'd9, 26'hFFF, 4'd1, 32'hA0, -1, 0);
        chk("perr_clean", {31'd0, protocol_error}, 32'd0);

        // misplaced WLAST: flag set, burst still 2 beats and written
        do_write(4'd4, 26'h30, 4'd1, 32'h55, 1'b1, 4'd4);
        chk("perr_set", {31'd0, protocol_error}, 32'd1);
        do_write(4'd4, 26'h34, 4'd0, 32'h66, 1'b0, 4'd4);
        chk("perr_sticky", {31'd0, protocol_error}, 32'd1);
        do_read(4'd0, 26'h30, 4'd1, 32'h55, -1, 0);

        // concurrent read and write
        fork
            do_write(4'd2, 26'h40, 4'd0, 32'hCAFE0000, 1'b0, 4'd2);
            do_read(4'd3, 26'h20, 4'd3, 32'h100, -1, 0);
        join

        // async reset in the middle of a stalled read burst
        RREADY = 0;
        ARVALID = 1; ARID = 4'd1; ARADDR = 26'h10; ARLEN = 4'd3;
        wait_hi(3, "arready_mid");
        @(posedge clk); #1;
        ARVALID = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_rvalid", {31'd0, RVALID}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("arst_rvalid", {31'd0, RVALID}, 32'd0);
        chk("arst_arready", {31'd0, ARREADY}, 32'd1);
        chk("arst_rlast", {31'd0, RLAST}, 32'd0);
        chk("arst_perr", {31'd0, protocol_error}, 32'd0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        do_read(4'd1, 26'h40, 4'd0, 32'hCAFE0000, -1, 0);
        do_read(4'd2, 26'h10, 4'd0, 32'hDEADBEEF, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI responder (memory side) for the core's memory ports: accepts read and write bursts, stores data in an internal word array, returns read beats and write responses.
- Sits in place of off-chip memory, behind the arbiter that merges the I-cache and D-cache AXI masters.
- Read and write channels run independently. Each channel has at most one outstanding transaction.

Parameters:
- ADDR_WIDTH, 26: word address width (addresses are word addresses).
- DATA_WIDTH, 32: data beat width.
- MEM_WORDS_LOG2, 12: storage depth is 2^MEM_WORDS_LOG2 words; the index is ADDR[MEM_WORDS_LOG2-1:0], higher bits are ignored (aliasing).
- READ_LATENCY, 2: cycles from AR handshake to the first RVALID. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- AWID  in  4  write transaction ID
- AWLEN  in  4  write burst length minus 1
- AWADDR  in  ADDR_WIDTH  write start word address
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- WLAST  in  1  last write beat
- WID  in  4  write data ID
- WDATA  in  DATA_WIDTH  write data
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- BID  out  4  write response ID
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- ARID  in  4  read transaction ID
- ARLEN  in  4  read burst length minus 1
- ARADDR  in  ADDR_WIDTH  read start word address
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- RLAST  out  1  last read beat
- RID  out  4  read data ID
- RDATA  out  DATA_WIDTH  read data
- protocol_error  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0): read FSM to R_IDLE, write FSM to W_IDLE. Outputs on reset: ARREADY=1, AWREADY=1, RVALID=0, RLAST=0, RID=0, RDATA=0, WREADY=0, BVALID=0, BID=0, protocol_error=0. Storage contents are not reset.
- Reset mid-burst abandons the burst with no response. Writes already committed stay in storage.
- Handshake rule: a transfer occurs on a rising edge with VALID&READY. Outputs are registered.
- Read FSM:
  - R_IDLE: ARREADY=1. On AR handshake, latch ARID, ARADDR and ARLEN, load latency counter = READ_LATENCY-1, go to R_WAIT. ARREADY drops the next cycle.
  - R_WAIT: decrement the counter. When it reaches 0, load beat 0 (RDATA=mem[addr], RVALID=1, RLAST=(ARLEN==0)) and go to R_BURST. First RVALID is READ_LATENCY cycles after the AR handshake.
  - R_BURST: hold RDATA, RID, RLAST and RVALID stable while RREADY=0.
    - On R handshake with RLAST=0: addr+1 (index wraps modulo 2^MEM_WORDS_LOG2), beat count+1, present the next beat the following cycle with no bubble.
    - On R handshake with RLAST=1: RVALID=0, go to R_IDLE. ARREADY=1 from the next cycle.
  - Burst length is ARLEN+1 beats, maximum 16.
- Write FSM:
  - W_IDLE: AWREADY=1. On AW handshake, latch AWID, AWADDR and AWLEN, go to W_DATA.
  - W_DATA: AWREADY=0, WREADY=1. Each W handshake writes mem[addr]=WDATA at that edge, then addr+1 with wrap.
    - Burst ends after AWLEN+1 beats regardless of WLAST.
    - If WLAST disagrees with the beat position, or WID≠latched AWID, set protocol_error (sticky until reset). The beat is still written.
    - After the final beat go to W_RESP.
  - W_RESP: BVALID=1, BID=latched AWID, hold until BREADY. On B handshake go to W_IDLE.
- Same-word collision: a read beat loaded on the same edge as a write beat to the same index returns the old data. The write is visible to beats loaded on later edges.
- Read and write FSMs never stall each other.

Test Plan:
- Single write then read: AW(id=3, addr=0x10, len=0), W 0xDEADBEEF with WLAST=1 → BVALID with BID=3. Then AR(id=5, addr=0x10, len=0) → RVALID exactly 2 cycles after the handshake, RDATA=0xDEADBEEF, RLAST=1, RID=5.
- Burst of 4: write 0x100..0x103 to addr 0x20, read back with len=3 → four consecutive RVALID beats, in order, RLAST on beat 3 only. ARREADY=0 until the cycle after the last beat.
- Backpressure: during a 4-beat read, drop RREADY for 3 cycles at beat 1 → RDATA and RLAST stay stable, no beat lost or duplicated.
- Index wrap: write a 2-beat burst at addr 0xFFF with MEM_WORDS_LOG2=12 → data lands at indices 0xFFF and 0x000. Reading addr 0x1000 returns the second word.
- Protocol error: AW(len=1), W beat 0 with WLAST=1 → protocol_error=1, burst still takes 2 beats, BVALID issued. Flag stays 1 until rst_n low.
- Concurrency and reset: run a read and a write to different addresses at once, then assert rst_n mid-read → RVALID=0 and ARREADY=1 immediately (async). Previously written words are still readable after reset.
